fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the team's synchronous FIFO. It drains a programmed number of words from the FIFO and presents them downstream on a valid/ready stream. It owns the FIFO pop and flush strobes, absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, and sustains one word per cycle when the consumer is always ready. It sits between the FIFO read port and the downstream mux/consumer.

## Interface
- DATA_WIDTH, 16, word width; matches FIFO data width
- LEN_WIDTH, 8, width of transfer length and delivered-word counter
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start transfer; sampled only in IDLE
- i_len  in  LEN_WIDTH  words to transfer, captured with i_start
- i_abort  in  1  abort active transfer; ignored in IDLE
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after a pop edge
- fifo_empty  in  1  FIFO empty flag
- fifo_pop  out  1  FIFO pop strobe (combinational from registered state and fifo_empty)
- fifo_flush  out  1  FIFO flush strobe
- o_data  out  DATA_WIDTH  stream data, head of output buffer
- o_valid  out  1  stream valid
- i_ready  in  1  stream ready
- o_busy  out  1  high in RUN, ABORT, DONE
- o_done  out  1  one-cycle pulse on normal completion
- o_count  out  LEN_WIDTH  words delivered in current/last transfer

## Operation
- States: IDLE, RUN, ABORT, DONE.
- IDLE: if i_start and i_len != 0, capture len, clear pop counter, occupancy, in-flight flag and o_count, go to RUN. If i_start and i_len == 0, go to DONE with no pops.
- RUN: fifo_pop = !fifo_empty && pops_issued < len && (occ + inflight − (o_valid && i_ready)) < 2. Each pop increments pops_issued and sets inflight for the next cycle. An in-flight word is written into the buffer on the following edge.
- Buffer is a 2-entry FIFO. Writes and reads in the same cycle are legal. o_data is the head and o_valid = (occ != 0). A handshake is o_valid && i_ready and increments o_count.
- RUN → DONE when a handshake makes o_count == len.
- DONE: o_done = 1 for exactly one cycle, then IDLE. o_count holds its final value until the next accepted start.
- RUN with i_abort: go to ABORT. Buffer and in-flight word are discarded, and no handshake is counted in that cycle. ABORT asserts fifo_flush = 1 for exactly one cycle, then IDLE, with no o_done pulse.
- Abort takes priority over completion in the same cycle. i_start outside IDLE is ignored.
- fifo_pop is never asserted outside RUN or while fifo_empty = 1.
- fifo_pop is never asserted once pops_issued == len. Total pops per transfer equal len exactly unless aborted.
- Counters do not wrap within a transfer: maximum len is 2^LEN_WIDTH − 1.

## Timing
- Reset state: IDLE. All counters, occ and inflight are 0. Outputs: fifo_pop 0, fifo_flush 0, o_valid 0, o_data 0, o_busy 0, o_done 0, o_count 0.
- Reset mid-transfer: immediate return to IDLE on the reset edge. Buffered data is lost. No flush or done is issued.
- Latency: i_start sampled at edge E0. fifo_pop can be high in the cycle after E0, and pops at edge E1. The word is captured at E2, and o_valid is high after E2.
- Throughput: with i_ready held high and FIFO non-empty, one pop and one handshake per cycle.
- Backpressure: with i_ready low, at most 2 words are popped beyond the last handshake. No word is dropped or duplicated.
- fifo_empty rising mid-transfer stalls pops only. Already-buffered words are still delivered.
- o_done is high in the cycle after the final handshake edge.

## Test plan
- Basic: FIFO preloaded with 0x0001..0x0004, i_len = 4, i_ready = 1 → 4 pops on consecutive cycles; o_data 0x0001..0x0004 on consecutive cycles; o_count = 4; one o_done pulse; no flush.
- Backpressure: i_len = 6, i_ready toggled 1,0,0,1,… → sequence delivered in order, no loss or duplication; occ ≤ 2 every cycle; exactly 6 pops.
- Starvation: FIFO holds 2 of 5 words; refill 3 words 10 cycles later → pops stall while fifo_empty = 1; transfer completes with o_count = 5 and one o_done.
- Zero length: i_start with i_len = 0 → no fifo_pop; o_done 1 cycle after start; o_count = 0.
- Abort: i_len = 8, i_abort after the 3rd handshake → one-cycle fifo_flush; o_valid drops; no o_done; IDLE next cycle; o_count = 3.
- Reset mid-transfer and ignored start: rst during RUN → all outputs return to their reset values next cycle. i_start while busy → no effect on len or counters.

Source files
------------

// File: rtl/fifo_reader.sv
// Purpose: drains a programmed number of words from a synchronous FIFO onto a valid/ready stream.
// Latency: start sampled at E0, first pop at E1, first o_valid after E2; one word per cycle sustained.
// Backpressure: pops throttle so buffered + in-flight words never exceed the 2-entry output buffer.
module fifo_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  fifo_flush,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [LEN_WIDTH-1:0]  o_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ABORT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  pops_q, pops_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic                  hs;
  logic [2:0]            pending;
  logic [1:0]            occ_rd;
  logic [LEN_WIDTH-1:0]  count_inc;

  // Outputs are decoded straight from registered state; buf0 is always the head.
  assign o_valid    = (occ_q != 2'd0);
  assign o_data     = buf0_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign fifo_flush = (state_q == ABORT);
  assign o_count    = count_q;

  // Handshake, pop decision and next-state computation for FSM, counters and buffer.
  always_comb begin
    hs        = (state_q == RUN) && o_valid && i_ready;
    // Words that will still occupy the buffer after this cycle's read, before any new pop.
    pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, hs};
    occ_rd    = occ_q - {1'b0, hs};
    count_inc = count_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    fifo_pop  = (state_q == RUN) && !fifo_empty && (pops_q < len_q) && (pending < 3'd2);

    state_d    = state_q;
    len_d      = len_q;
    pops_d     = pops_q;
    count_d    = count_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          len_d      = i_len;
          pops_d     = '0;
          count_d    = '0;
          occ_d      = 2'd0;
          inflight_d = 1'b0;
          state_d    = (i_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (i_abort) begin
          // Abort wins over completion: drop buffered and in-flight data, count nothing.
          occ_d      = 2'd0;
          inflight_d = 1'b0;
          state_d    = ABORT;
        end else begin
          if (hs) begin
            buf0_d  = buf1_q;
            count_d = count_inc;
            if (count_inc == len_q) begin
              state_d = DONE;
            end
          end
          // The word popped last cycle lands behind whatever survives this cycle's read.
          if (inflight_q) begin
            if (occ_rd == 2'd0) begin
              buf0_d = fifo_data;
            end else begin
              buf1_d = fifo_data;
            end
          end
          occ_d      = occ_rd + {1'b0, inflight_q};
          inflight_d = fifo_pop;
          pops_d     = pops_q + {{(LEN_WIDTH-1){1'b0}}, fifo_pop};
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any transfer without flush or done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      pops_q     <= '0;
      count_q    <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pops_q     <= pops_d;
      count_q    <= count_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO (registered read) on its read port.
module tb_fifo_reader;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [LW-1:0] i_len;
  logic          i_abort;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_busy;
  logic          o_done;
  logic [LW-1:0] o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_abort(i_abort),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_flush(fifo_flush), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
  );

  // FIFO model: pointer-based, data appears the cycle after a pop edge.
  logic [DW-1:0] fmem [0:255];
  int wptr = 0;
  int rptr = 0;
  int pop_cnt = 0;
  assign fifo_empty = (wptr == rptr);

  always @(posedge clk) begin
    if (rst || fifo_flush) begin
      rptr <= wptr;
    end else if (fifo_pop) begin
      fifo_data <= fmem[rptr[7:0]];
      rptr      <= rptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // Stream monitor sampled mid-cycle.
  logic [DW-1:0] rx [0:255];
  int rx_n = 0;
  int done_cnt = 0;
  int flush_cnt = 0;
  int bad_pop = 0;

  always @(negedge clk) begin
    if (o_valid && i_ready) begin
      rx[rx_n[7:0]] <= o_data;
      rx_n <= rx_n + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (fifo_flush) flush_cnt <= flush_cnt + 1;
    if (fifo_pop && fifo_empty) bad_pop <= bad_pop + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fmem[wptr[7:0]] = v;
    wptr = wptr + 1;
  endtask

  // Presents i_start for one edge (E0); returns just after E0.
  task automatic start(input logic [LW-1:0] len);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_len   = len;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pop"},   32'(fifo_pop),   32'd0);
    check({tag, "_flush"}, 32'(fifo_flush), 32'd0);
    check({tag, "_valid"}, 32'(o_valid),    32'd0);
    check({tag, "_data"},  32'(o_data),     32'd0);
    check({tag, "_busy"},  32'(o_busy),     32'd0);
    check({tag, "_done"},  32'(o_done),     32'd0);
    check({tag, "_count"}, 32'(o_count),    32'd0);
  endtask

  logic          pop_a  [1:8];
  logic          vld_a  [1:8];
  logic          done_a [1:8];
  logic [DW-1:0] dat_a  [1:8];
  int pop0, rx0, done0, flush0;
  bit got;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_len = '0; i_abort = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic: 4 words, consumer always ready.
    for (int i = 1; i <= 4; i++) push(16'(i));
    i_ready = 1'b1;
    pop0 = pop_cnt; rx0 = rx_n; done0 = done_cnt; flush0 = flush_cnt;
    start(8'd4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      pop_a[k] = fifo_pop; vld_a[k] = o_valid; done_a[k] = o_done; dat_a[k] = o_data;
    end
    #1;
    for (int k = 1; k <= 8; k++) begin
      check("basic_pop",  32'(pop_a[k]),  32'(k <= 4));
      check("basic_vld",  32'(vld_a[k]),  32'(k >= 3 && k <= 6));
      check("basic_done", 32'(done_a[k]), 32'(k == 7));
      if (k >= 3 && k <= 6) check("basic_data", 32'(dat_a[k]), 32'(k - 2));
    end
    check("basic_count",  32'(o_count), 32'd4);
    check("basic_busy",   32'(o_busy), 32'd0);
    check("basic_npops",  32'(pop_cnt - pop0), 32'd4);
    check("basic_ndone",  32'(done_cnt - done0), 32'd1);
    check("basic_nflush", 32'(flush_cnt - flush0), 32'd0);

    // Backpressure: ready pattern 1,0,0,1 repeating.
    for (int i = 0; i < 6; i++) push(16'(16'h10 + i));
    pop0 = pop_cnt; rx0 = rx_n; done0 = done_cnt;
    i_ready = 1'b1;
    start(8'd6);
    got = 1'b0;
    for (int j = 0; j < 80; j++) begin
      i_ready = ((j % 4) == 0) || ((j % 4) == 3);
      @(negedge clk); #1;
      check("bp_ahead", 32'(((pop_cnt - pop0) - (rx_n - rx0)) <= 2), 32'd1);
      if (o_done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("bp_finished", 32'(got), 32'd1);
    for (int i = 0; i < 6; i++) check("bp_data", 32'(rx[8'(rx0 + i)]), 32'(16'h10 + i));
    check("bp_nrx",   32'(rx_n - rx0), 32'd6);
    check("bp_npops", 32'(pop_cnt - pop0), 32'd6);
    check("bp_count", 32'(o_count), 32'd6);
    check("bp_ndone", 32'(done_cnt - done0), 32'd1);
    @(posedge clk); #1;
    i_ready = 1'b1;

    // Starvation: only 2 of 5 words available, rest arrive 10 cycles later.
    push(16'h20); push(16'h21);
    pop0 = pop_cnt; rx0 = rx_n; done0 = done_cnt;
    start(8'd5);
    repeat (10) @(posedge clk);
    #1;
    check("starve_count", 32'(o_count), 32'd2);
    check("starve_busy",  32'(o_busy), 32'd1);
    check("starve_valid", 32'(o_valid), 32'd0);
    check("starve_npops", 32'(pop_cnt - pop0), 32'd2);
    push(16'h22); push(16'h23); push(16'h24);
    got = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk); #1;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    check("starve_finished", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) check("starve_data", 32'(rx[8'(rx0 + i)]), 32'(16'h20 + i));
    check("starve_count_end", 32'(o_count), 32'd5);
    check("starve_npops_end", 32'(pop_cnt - pop0), 32'd5);
    check("starve_ndone",     32'(done_cnt - done0), 32'd1);

    // Zero length with a word waiting in the FIFO: no pop, done next cycle.
    push(16'h99);
    pop0 = pop_cnt;
    start(8'd0);
    @(negedge clk);
    check("zero_done",  32'(o_done), 32'd1);
    check("zero_pop",   32'(fifo_pop), 32'd0);
    check("zero_count", 32'(o_count), 32'd0);
    check("zero_busy",  32'(o_busy), 32'd1);
    @(negedge clk);
    check("zero_done_off", 32'(o_done), 32'd0);
    check("zero_busy_off", 32'(o_busy), 32'd0);
    #1;
    check("zero_npops", 32'(pop_cnt - pop0), 32'd0);

    // Abort after the 3rd handshake; 0x99 is still at the FIFO head.
    for (int i = 0; i < 7; i++) push(16'(16'h30 + i));
    rx0 = rx_n; done0 = done_cnt; flush0 = flush_cnt;
    i_ready = 1'b1;
    start(8'd8);
    got = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (o_count == 8'd2 && o_valid && i_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_reached3", 32'(got), 32'd1);
    @(posedge clk); #1;
    i_abort = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_flush", 32'(fifo_flush), 32'd1);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_busy",  32'(o_busy), 32'd1);
    check("abort_done",  32'(o_done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_idle",      32'(o_busy), 32'd0);
    check("abort_flush_off", 32'(fifo_flush), 32'd0);
    check("abort_count",     32'(o_count), 32'd3);
    #1;
    check("abort_nflush", 32'(flush_cnt - flush0), 32'd1);
    check("abort_ndone",  32'(done_cnt - done0), 32'd0);
    check("abort_nrx",    32'(rx_n - rx0), 32'd3);
    check("abort_d0", 32'(rx[8'(rx0)]),     32'h99);
    check("abort_d1", 32'(rx[8'(rx0 + 1)]), 32'h30);
    check("abort_d2", 32'(rx[8'(rx0 + 2)]), 32'h31);

    // Start while busy must not disturb the running transfer.
    for (int i = 0; i < 4; i++) push(16'(16'h40 + i));
    pop0 = pop_cnt; rx0 = rx_n; done0 = done_cnt;
    i_ready = 1'b0;
    start(8'd4);
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b1; i_len = 8'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_ready = 1'b1;
    got = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk); #1;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    check("ign_finished", 32'(got), 32'd1);
    check("ign_count", 32'(o_count), 32'd4);
    check("ign_npops", 32'(pop_cnt - pop0), 32'd4);
    check("ign_ndone", 32'(done_cnt - done0), 32'd1);
    for (int i = 0; i < 4; i++) check("ign_data", 32'(rx[8'(rx0 + i)]), 32'(16'h40 + i));

    // Reset in the middle of a stalled transfer with a full output buffer.
    for (int i = 0; i < 4; i++) push(16'(16'h50 + i));
    done0 = done_cnt; flush0 = flush_cnt;
    i_ready = 1'b0;
    start(8'd4);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    #1;
    check("midrst_nflush", 32'(flush_cnt - flush0), 32'd0);
    check("midrst_ndone",  32'(done_cnt - done0), 32'd0);
    check("pop_on_empty",  32'(bad_pop), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
